compl_arbiter: RTL and testbench
================================

# compl_arbiter

Shared two's-complement (negation) service for the KGP-RISC datapath: arbitrates between two requesters (port 0: ALU negate/subtract path, port 1: multiply/divide sign-correction path) for a single WIDTH-bit complementing stage. It registers the winning operand, computes ~A + 1 in a dedicated cycle, and returns the result with a valid/ready response handshake tagged with the requester ID.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- req[1:0]  input  2  per-requester request; held high until matching gnt
- op0  input  WIDTH  operand of requester 0, stable while req[0] high
- op1  input  WIDTH  operand of requester 1, stable while req[1] high
- gnt[1:0]  output  2  one-hot, single-cycle grant; operand captured that cycle
- rsp_valid  output  1  result available
- rsp_id  output  1  requester that owns the current result
- rsp_data  output  WIDTH  ~operand + 1, modulo 2^WIDTH
- rsp_ovf  output  1  operand was the most negative value (1 followed by zeros)
- rsp_ready  input  1  consumer accepts result
- busy  output  1  FSM not in IDLE

## Operation
- FSM states: IDLE, COMPUTE, RESP.
- IDLE: if any req bit high, pick winner, pulse gnt[winner], latch operand and ID, go COMPUTE; else stay.
- COMPUTE: register rsp_data = ~opnd + 1 (WIDTH-bit, carry-out discarded), rsp_ovf = (opnd == {1'b1, {WIDTH-1{1'b0}}}); go RESP.
- RESP: rsp_valid = 1; rsp_id/rsp_data/rsp_ovf held stable; on rsp_ready go IDLE, else stay.
- gnt is asserted only in IDLE; requests during COMPUTE/RESP wait, with no grant and no loss.
- Arbitration: see Configuration. Priority pointer updates only on a grant.
- Zero operand: result 0, ovf 0. 0x80000000: result 0x80000000, ovf 1.
- busy = (state != IDLE).

## Timing
- Reset (rst low, any time): state IDLE, gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_ovf = 0, busy = 0, priority pointer favours requester 0. An in-flight operation is discarded; its requester must re-request.
- Grant latency: req sampled high in IDLE at edge N → gnt high during cycle N (combinational from state/req, registered capture at edge N+1).
- Result latency: rsp_valid rises 2 cycles after the grant cycle.
- rsp_ready high in the first RESP cycle → IDLE next cycle; the next grant comes no earlier than that IDLE cycle. Minimum spacing between operations is 3 cycles.
- rsp_ready low: RESP holds indefinitely; outputs do not change.
- rsp_ready outside RESP: ignored.
- Requester dropping req before gnt: legal; the request is withdrawn, with no grant.

## Configuration
- COMPL_RR_EN defined: round-robin arbitration. On simultaneous req = 2'b11, grant the requester not granted last. After reset, requester 0 wins the first tie.
- COMPL_RR_EN undefined: fixed priority. Requester 0 always wins ties, and the pointer register is not implemented.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset mid-op: grant op0 = 5, assert rst low during COMPUTE → all outputs 0, state IDLE; release, no rsp_valid until a new req.
- Single request: req = 01, op0 = 0x00000005 → gnt = 01 same cycle; rsp_valid 2 cycles later with rsp_data = 0xFFFFFFFB, rsp_id = 0, rsp_ovf = 0.
- Boundary values: op1 = 0x80000000 → rsp_data = 0x80000000, rsp_ovf = 1. op1 = 0 → rsp_data = 0, rsp_ovf = 0.
- Back-pressure: hold rsp_ready low 5 cycles with req[1] pending → rsp_valid/data stable, gnt stays 00. Release → IDLE, then gnt = 10.
- Tie, COMPL_RR_EN defined: req = 11 held continuously, rsp_ready = 1 → grants alternate 01, 10, 01; rsp_id alternates 0, 1, 0.
- Tie, COMPL_RR_EN undefined: same stimulus → every grant 01 until req[0] drops, then 10.

Source files
------------

// File: rtl/compl_arbiter.sv
// ============================================================================
// Module   : compl_arbiter
// Brief    : Two-requester arbiter in front of a shared two's-complement
//            (~A + 1) stage with a valid/ready response tagged by requester.
//            Optional macro COMPL_RR_EN selects round-robin tie-breaking;
//            otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module compl_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] op0,
  input  logic [WIDTH-1:0] op1,
  output logic [1:0]       gnt,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_winner;
  logic             w_grant;
  logic [WIDTH-1:0] r_opnd;
  logic             r_id;
  logic [WIDTH-1:0] r_data;
  logic             r_ovf;

`ifdef COMPL_RR_EN
  // Pointer names the requester that wins the next tie.
  logic r_favourOne;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_favourOne <= 1'b0;
    end else if (w_grant) begin
      r_favourOne <= ~w_winner;
    end
  end

  always_comb begin
    w_winner = (req == 2'b11) ? r_favourOne : ~req[0];
  end
`else
  always_comb begin
    w_winner = ~req[0];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_grant     = 1'b0;
    gnt         = 2'b00;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_grant     = 1'b1;
          gnt         = w_winner ? 2'b10 : 2'b01;
          w_stateNext = COMPUTE;
        end
      end
      COMPUTE: w_stateNext = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Result registers change only on COMPUTE, so they stay frozen through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opnd <= '0;
      r_id   <= 1'b0;
      r_data <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_opnd <= w_winner ? op1 : op0;
        r_id   <= w_winner;
      end
      if (r_state == COMPUTE) begin
        r_data <= ~r_opnd + {{(WIDTH-1){1'b0}}, 1'b1};
        r_ovf  <= (r_opnd == C_MOST_NEG);
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_ovf   = r_ovf;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_compl_arbiter.sv
// ============================================================================
// Module   : tb_compl_arbiter
// Brief    : Directed bench for compl_arbiter; follows COMPL_RR_EN like the DUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compl_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [WIDTH-1:0] op0;
  logic [WIDTH-1:0] op1;
  logic [1:0]       gnt;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ovf;
  logic             rsp_ready;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  compl_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op0       (op0),
    .op1       (op1),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: how far the current job has progressed (0 = no job).
  int               mPhase = 0;
  bit               mFavourOne = 0;
  logic [WIDTH-1:0] mOperand = '0;
  bit               mOwner = 0;
  logic [WIDTH-1:0] mResult = '0;
  bit               mOvf = 0;

  bit          collect = 0;
  logic [1:0]  gntLog[$];
  bit          idLog[$];

  function automatic bit pickWinner(input logic [1:0] r, input bit favourOne);
`ifdef COMPL_RR_EN
    if (r == 2'b11) return favourOne;
`endif
    return (r == 2'b10);
  endfunction

  always @(negedge clk) begin
    logic [1:0]       expGnt;
    logic [WIDTH-1:0] neg;
    bit               w;
    if (!rst) begin
      mPhase = 0; mFavourOne = 0; mResult = '0; mOvf = 0; mOwner = 0;
      check("rst_gnt",   {30'd0, gnt},       '0);
      check("rst_valid", {31'd0, rsp_valid}, '0);
      check("rst_id",    {31'd0, rsp_id},    '0);
      check("rst_data",  rsp_data,           '0);
      check("rst_ovf",   {31'd0, rsp_ovf},   '0);
      check("rst_busy",  {31'd0, busy},      '0);
    end else begin
      w = pickWinner(req, mFavourOne);
      expGnt = (mPhase == 0 && req != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
      check("gnt",   {30'd0, gnt},       {30'd0, expGnt});
      check("valid", {31'd0, rsp_valid}, {31'd0, mPhase == 2});
      check("busy",  {31'd0, busy},      {31'd0, mPhase != 0});
      if (mPhase == 2) begin
        check("id",   {31'd0, rsp_id},  {31'd0, mOwner});
        check("data", rsp_data,         mResult);
        check("ovf",  {31'd0, rsp_ovf}, {31'd0, mOvf});
      end
      if (collect && gnt != 2'b00) gntLog.push_back(gnt);
      if (collect && rsp_valid && rsp_ready) idLog.push_back(rsp_id);
      case (mPhase)
        0: if (expGnt != 2'b00) begin
             mOperand = w ? op1 : op0;
             mOwner = w;
             mFavourOne = !w;
             mPhase = 1;
           end
        1: begin
             neg = '0 - mOperand;
             mResult = neg;
             mOvf = (mOperand != '0) && (neg == mOperand);
             mPhase = 2;
           end
        default: if (rsp_ready) mPhase = 0;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bit expIds[3];
    rst = 1'b0; req = 2'b00; op0 = '0; op1 = '0; rsp_ready = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);

    // Reset mid-operation.
    req = 2'b01; op0 = 32'd5;
    step(1);
    req = 2'b00; rst = 1'b0;
    settle();
    check("lit_midrst_busy",  {31'd0, busy},      '0);
    check("lit_midrst_valid", {31'd0, rsp_valid}, '0);
    step(1);
    rst = 1'b1;
    step(4);
    check("lit_norsp_after_rst", {31'd0, rsp_valid}, '0);

    // Single request on port 0.
    rsp_ready = 1'b1;
    req = 2'b01; op0 = 32'h0000_0005;
    settle();
    check("lit_single_gnt", {30'd0, gnt}, 32'd1);
    step(1);
    req = 2'b00;
    step(1);
    settle();
    check("lit_single_valid", {31'd0, rsp_valid}, 32'd1);
    check("lit_single_data",  rsp_data,           32'hFFFF_FFFB);
    check("lit_single_id",    {31'd0, rsp_id},    32'd0);
    step(1);

    // Boundary operands on port 1.
    req = 2'b10; op1 = 32'h8000_0000;
    step(1);
    req = 2'b00;
    step(1);
    settle();
    check("lit_mostneg_data", rsp_data,          32'h8000_0000);
    check("lit_mostneg_ovf",  {31'd0, rsp_ovf},  32'd1);
    check("lit_mostneg_id",   {31'd0, rsp_id},   32'd1);
    step(1);
    req = 2'b10; op1 = 32'h0;
    step(1);
    req = 2'b00;
    step(1);
    settle();
    check("lit_zero_data", rsp_data,         32'h0);
    check("lit_zero_ovf",  {31'd0, rsp_ovf}, 32'd0);
    step(1);

    // Back-pressure with a pending request on port 1.
    rsp_ready = 1'b0;
    req = 2'b01; op0 = 32'd7;
    step(1);
    req = 2'b10; op1 = 32'd3;
    step(1);
    for (int i = 0; i < 5; i++) begin
      settle();
      check("lit_bp_gnt",  {30'd0, gnt},  32'd0);
      check("lit_bp_data", rsp_data,      32'hFFFF_FFF9);
      step(1);
    end
    rsp_ready = 1'b1;
    step(1);
    settle();
    check("lit_bp_release_gnt", {30'd0, gnt}, 32'd2);
    step(1);
    req = 2'b00;
    step(3);

    // Tie: both requesters held.
    collect = 1'b1;
    req = 2'b11; op0 = 32'h10; op1 = 32'h20;
    step(9);
    req = 2'b10;
    step(1);
    req = 2'b00;
    step(3);
    collect = 1'b0;

`ifdef COMPL_RR_EN
    expIds = '{1'b0, 1'b1, 1'b0};
    check("lit_tie_g0", (gntLog.size() > 0) ? {30'd0, gntLog[0]} : 32'hDEAD, 32'd1);
    check("lit_tie_g1", (gntLog.size() > 1) ? {30'd0, gntLog[1]} : 32'hDEAD, 32'd2);
    check("lit_tie_g2", (gntLog.size() > 2) ? {30'd0, gntLog[2]} : 32'hDEAD, 32'd1);
`else
    expIds = '{1'b0, 1'b0, 1'b0};
    check("lit_tie_g0", (gntLog.size() > 0) ? {30'd0, gntLog[0]} : 32'hDEAD, 32'd1);
    check("lit_tie_g1", (gntLog.size() > 1) ? {30'd0, gntLog[1]} : 32'hDEAD, 32'd1);
    check("lit_tie_g2", (gntLog.size() > 2) ? {30'd0, gntLog[2]} : 32'hDEAD, 32'd1);
`endif
    check("lit_tie_g3", (gntLog.size() > 3) ? {30'd0, gntLog[3]} : 32'hDEAD, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("lit_tie_id", (idLog.size() > i) ? {31'd0, idLog[i]} : 32'hDEAD, {31'd0, expIds[i]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
